// File: rtl/mem_access.sv
// Memory-access pipeline stage: doubleword load/store against an internal data
// memory with LAT-cycle latency, branch resolution, and the packed MEM/WB buffer.
module mem_access #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [202:0] inBuf,
  input  logic         in_valid,
  output logic [134:0] outBuf,
  output logic         PCSrc,
  output logic [63:0]  BranchTarget,
  output logic         stall
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [3:0]  LAST = 4'(LAT - 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [134:0]   out_q;
  logic           pcsrc_q;
  logic [63:0]    bt_q;
  logic [63:0]    mem_q [DEPTH];

  logic [4:0]     reg_w;
  logic [63:0]    store_data, alu_res, br_tgt, ld_data;
  logic           zero, branch, mem_wr, mem_rd, mem_to_reg, reg_write;
  logic [AW-1:0]  idx;
  logic           memop, complete, accept;
  logic [134:0]   result;

  assign reg_w      = inBuf[4:0];
  assign store_data = inBuf[68:5];
  assign alu_res    = inBuf[132:69];
  assign br_tgt     = inBuf[196:133];
  assign zero       = inBuf[197];
  assign branch     = inBuf[198];
  assign mem_wr     = inBuf[199];
  assign mem_rd     = inBuf[200];
  assign mem_to_reg = inBuf[201];
  assign reg_write  = inBuf[202];

  // Low three bits dropped (doubleword aligned); upper bits dropped (wraps).
  assign idx      = alu_res[AW+2:3];
  assign memop    = in_valid & (mem_rd | mem_wr);
  assign complete = (LAT == 1) || (state_q == WAIT && cnt_q == LAST);
  assign accept   = in_valid & (~memop | complete);
  assign stall    = rst_n & memop & ~complete;
  assign ld_data  = mem_rd ? mem_q[idx] : '0;
  assign result   = {reg_write, mem_to_reg, alu_res, ld_data, reg_w};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (memop && LAT > 1) begin
          state_d = WAIT;
          cnt_d   = 4'd1;
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      pcsrc_q <= 1'b0;
      bt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        out_q   <= result;
        pcsrc_q <= branch & zero;
        bt_q    <= br_tgt;
      end else begin
        out_q   <= '0;
        pcsrc_q <= 1'b0;
      end
    end
  end

  // Memory is not reset; the read above sees old contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst_n && accept && mem_wr) mem_q[idx] <= store_data;
  end

  assign outBuf       = out_q;
  assign PCSrc        = pcsrc_q;
  assign BranchTarget = bt_q;

endmodule
